// File: rtl/core_pkg.sv
// Shared MIPS core definitions: load-size encodings, write-back source indices, default widths.
package core_pkg;

    localparam int unsigned DATA_W_DEF     = 32;
    localparam int unsigned REG_ADDR_W_DEF = 5;

    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;

    localparam int unsigned SRC_ALU  = 0;
    localparam int unsigned SRC_MEM  = 1;
    localparam int unsigned SRC_LINK = 2;
    localparam int unsigned SRC_AUX  = 3;

endpackage

// File: rtl/mod_writeback_unit_if.sv
// Upstream instruction bus into the write-back stage.
interface mod_writeback_unit_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_SRC),
    parameter int unsigned REG_ADDR_W = 5
);
    logic                        in_valid;
    logic                        in_ready;
    logic [NUM_SRC*DATA_W-1:0]   src_data;
    logic [SEL_W-1:0]            src_sel;
    logic [1:0]                  load_size;
    logic                        load_unsigned;
    logic [1:0]                  byte_offset;
    logic                        reg_write_in;
    logic [REG_ADDR_W-1:0]       rd_in;

    modport master (
        output in_valid, src_data, src_sel, load_size, load_unsigned,
               byte_offset, reg_write_in, rd_in,
        input  in_ready
    );

    modport slave (
        input  in_valid, src_data, src_sel, load_size, load_unsigned,
               byte_offset, reg_write_in, rd_in,
        output in_ready
    );
endinterface

// File: rtl/mod_writeback_unit_load_align.sv
// Big-endian lane select, sign/zero extension and misalignment detection for memory loads.
module mod_load_align
    import core_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] mem_word,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [1:0]        byte_offset,
    output logic [DATA_W-1:0] aligned_c,
    output logic              misalign_c
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        aligned_c  = mem_word;
        misalign_c = 1'b0;
        byte_lane  = '0;
        half_lane  = '0;
        case (load_size)
            LS_HALF: begin
                misalign_c = byte_offset[0];
                half_lane  = byte_offset[1] ? mem_word[15:0] : mem_word[31:16];
                aligned_c  = {{(DATA_W-16){!load_unsigned && half_lane[15]}}, half_lane};
            end
            LS_BYTE: begin
                case (byte_offset)
                    2'd0:    byte_lane = mem_word[31:24];
                    2'd1:    byte_lane = mem_word[23:16];
                    2'd2:    byte_lane = mem_word[15:8];
                    default: byte_lane = mem_word[7:0];
                endcase
                aligned_c = {{(DATA_W-8){!load_unsigned && byte_lane[7]}}, byte_lane};
            end
            // word and the reserved encoding both load a full aligned word
            default: misalign_c = (byte_offset != 2'd0);
        endcase
    end
endmodule

// File: rtl/mod_writeback_unit.sv
// Registered MIPS write-back stage: source mux, load alignment and valid/stall/flush output register.
module mod_writeback_unit
    import core_pkg::*;
#(
    parameter int unsigned DATA_W     = DATA_W_DEF,
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned SEL_W      = $clog2(NUM_SRC),
    parameter int unsigned MEM_SRC    = SRC_MEM,
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    mod_writeback_unit_if.slave   up,
    input  logic                  wb_stall,
    input  logic                  flush,
    output logic                  wb_valid,
    output logic [DATA_W-1:0]     write_data,
    output logic [REG_ADDR_W-1:0] write_reg,
    output logic                  reg_write_en,
    output logic                  misalign_err
);
    logic [DATA_W-1:0] sel_word;
    logic [DATA_W-1:0] aligned;
    logic [DATA_W-1:0] next_data;
    logic              sel_ok;
    logic              is_mem;
    logic              misalign;
    logic              load_err;
    logic              next_en;

    assign up.in_ready = !wb_stall;

    mod_load_align #(.DATA_W(DATA_W)) u_align (
        .mem_word      (up.src_data[MEM_SRC*DATA_W +: DATA_W]),
        .load_size     (up.load_size),
        .load_unsigned (up.load_unsigned),
        .byte_offset   (up.byte_offset),
        .aligned_c     (aligned),
        .misalign_c    (misalign)
    );

    // Out-of-range selects match no source and leave sel_ok low
    always_comb begin
        sel_word = '0;
        sel_ok   = 1'b0;
        for (int k = 0; k < int'(NUM_SRC); k++) begin
            if (up.src_sel == SEL_W'(k)) begin
                sel_word = up.src_data[k*DATA_W +: DATA_W];
                sel_ok   = 1'b1;
            end
        end
    end

    always_comb begin
        is_mem    = sel_ok && (up.src_sel == SEL_W'(MEM_SRC));
        load_err  = is_mem && misalign;
        next_data = (!sel_ok || load_err) ? '0 : (is_mem ? aligned : sel_word);
        next_en   = up.reg_write_in && (up.rd_in != '0) && sel_ok && !load_err;
    end

    // Priority: flush > stall > capture > bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid     <= 1'b0;
            write_data   <= '0;
            write_reg    <= '0;
            reg_write_en <= 1'b0;
            misalign_err <= 1'b0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            reg_write_en <= 1'b0;
            misalign_err <= 1'b0;
        end else if (wb_stall) begin
            wb_valid     <= wb_valid;
        end else if (up.in_valid) begin
            wb_valid     <= 1'b1;
            write_data   <= next_data;
            write_reg    <= up.rd_in;
            reg_write_en <= next_en;
            misalign_err <= load_err;
        end else begin
            wb_valid     <= 1'b0;
            reg_write_en <= 1'b0;
            misalign_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mod_writeback_unit.sv
// Bench for mod_writeback_unit: a 4-source and a 3-source instance share one stimulus stream.
module tb_mod_writeback_unit;

    typedef struct packed {
        logic        v;
        logic [31:0] d;
        logic [4:0]  r;
        logic        en;
        logic        err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         stall = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         uns = 1'b0;
    logic         rw = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic [1:0]   ls = 2'd0;
    logic [1:0]   off = 2'd0;
    logic [4:0]   rd = 5'd0;
    logic [127:0] src = '0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    exp_t m4, m3;

    logic        v4, en4, e4, v3, en3, e3;
    logic [31:0] d4, d3;
    logic [4:0]  r4, r3;

    always #5 clk = ~clk;

    mod_writeback_unit_if #(.DATA_W(32), .NUM_SRC(4), .REG_ADDR_W(5)) bus4 ();
    mod_writeback_unit_if #(.DATA_W(32), .NUM_SRC(3), .REG_ADDR_W(5)) bus3 ();

    assign bus4.in_valid      = in_valid;
    assign bus4.src_data      = src;
    assign bus4.src_sel       = sel;
    assign bus4.load_size     = ls;
    assign bus4.load_unsigned = uns;
    assign bus4.byte_offset   = off;
    assign bus4.reg_write_in  = rw;
    assign bus4.rd_in         = rd;

    assign bus3.in_valid      = in_valid;
    assign bus3.src_data      = src[95:0];
    assign bus3.src_sel       = sel;
    assign bus3.load_size     = ls;
    assign bus3.load_unsigned = uns;
    assign bus3.byte_offset   = off;
    assign bus3.reg_write_in  = rw;
    assign bus3.rd_in         = rd;

    mod_writeback_unit #(.DATA_W(32), .NUM_SRC(4), .MEM_SRC(1), .REG_ADDR_W(5)) dut4 (
        .clk(clk), .rst(rst), .up(bus4.slave), .wb_stall(stall), .flush(flush),
        .wb_valid(v4), .write_data(d4), .write_reg(r4), .reg_write_en(en4), .misalign_err(e4)
    );

    mod_writeback_unit #(.DATA_W(32), .NUM_SRC(3), .MEM_SRC(1), .REG_ADDR_W(5)) dut3 (
        .clk(clk), .rst(rst), .up(bus3.slave), .wb_stall(stall), .flush(flush),
        .wb_valid(v3), .write_data(d3), .write_reg(r3), .reg_write_en(en3), .misalign_err(e3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // What a capture must produce, from the load rules stated as shifts and masks
    function automatic exp_t cap(input int nsrc);
        exp_t        e;
        logic [31:0] w;
        logic [31:0] lane;
        logic        ill;
        int          s;
        e     = '0;
        e.v   = 1'b1;
        e.r   = rd;
        ill   = (int'(sel) >= nsrc);
        w     = 32'(src >> (32 * int'(sel)));
        e.d   = w;
        if (!ill && int'(sel) == 1) begin
            s = 8 * int'(off);
            case (ls)
                2'b01: begin
                    if (off[0]) e.err = 1'b1;
                    else begin
                        lane = (w >> (16 - s)) & 32'h0000FFFF;
                        e.d  = (!uns && lane[15]) ? (lane | 32'hFFFF0000) : lane;
                    end
                end
                2'b10: begin
                    lane = (w >> (24 - s)) & 32'h000000FF;
                    e.d  = (!uns && lane[7]) ? (lane | 32'hFFFFFF00) : lane;
                end
                default: e.err = (off != 2'd0);
            endcase
        end
        if (ill || e.err) e.d = '0;
        e.en = rw && (rd != 5'd0) && !ill && !e.err;
        return e;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 <= '0;
            m3 <= '0;
        end else if (flush) begin
            m4.v <= 1'b0; m4.en <= 1'b0; m4.err <= 1'b0;
            m3.v <= 1'b0; m3.en <= 1'b0; m3.err <= 1'b0;
        end else if (!stall) begin
            if (in_valid) begin
                m4 <= cap(4);
                m3 <= cap(3);
            end else begin
                m4.v <= 1'b0; m4.en <= 1'b0; m4.err <= 1'b0;
                m3.v <= 1'b0; m3.en <= 1'b0; m3.err <= 1'b0;
            end
        end
    end

    // Every cycle: both DUTs against the model; data and address only when valid
    always @(negedge clk) begin
        chk("m4.valid", 32'(v4), 32'(m4.v));
        chk("m4.en",    32'(en4), 32'(m4.en));
        chk("m4.err",   32'(e4), 32'(m4.err));
        chk("m3.valid", 32'(v3), 32'(m3.v));
        chk("m3.en",    32'(en3), 32'(m3.en));
        chk("m3.err",   32'(e3), 32'(m3.err));
        chk("in_ready", 32'(bus4.in_ready), 32'(!stall));
        if (m4.v) begin
            chk("m4.data", d4, m4.d);
            chk("m4.reg",  32'(r4), 32'(m4.r));
        end
        if (m3.v) begin
            chk("m3.data", d3, m3.d);
            chk("m3.reg",  32'(r3), 32'(m3.r));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic lit4(input string n, input logic v, input logic [31:0] d, input logic en, input logic err);
        chk({n, ".valid"}, 32'(v4), 32'(v));
        chk({n, ".data"},  d4, d);
        chk({n, ".en"},    32'(en4), 32'(en));
        chk({n, ".err"},   32'(e4), 32'(err));
    endtask

    task automatic drive(input logic [1:0] s, input logic [1:0] l, input logic [1:0] o,
                         input logic u, input logic [4:0] r);
        in_valid = 1'b1; rw = 1'b1;
        sel = s; ls = l; off = o; uns = u; rd = r;
    endtask

    initial begin
        #1;
        lit4("reset0", 1'b0, 32'h0, 1'b0, 1'b0);
        repeat (2) cyc();
        lit4("reset1", 1'b0, 32'h0, 1'b0, 1'b0);
        rst = 1'b0;

        src = {32'h0, 32'h0, 32'h12F45678, 32'h0};
        drive(2'd1, 2'b10, 2'd1, 1'b0, 5'd3);
        cyc();
        lit4("byte_s", 1'b1, 32'hFFFFFFF4, 1'b1, 1'b0);
        chk("byte_s.reg", 32'(r4), 32'd3);

        src = {32'h0, 32'h0, 32'h8001ABCD, 32'h0};
        drive(2'd1, 2'b01, 2'd0, 1'b1, 5'd4);
        cyc();
        lit4("half_u", 1'b1, 32'h00008001, 1'b1, 1'b0);

        off = 2'd1;
        cyc();
        lit4("half_mis", 1'b1, 32'h0, 1'b0, 1'b1);

        src = {32'h0, 32'h0, 32'h12F456F8, 32'h0};
        drive(2'd1, 2'b10, 2'd3, 1'b1, 5'd6);
        cyc();
        lit4("byte_u3", 1'b1, 32'h000000F8, 1'b1, 1'b0);

        src = {32'h0, 32'h0, 32'h1234ABCD, 32'h0};
        drive(2'd1, 2'b01, 2'd2, 1'b0, 5'd7);
        cyc();
        lit4("half_s2", 1'b1, 32'hFFFFABCD, 1'b1, 1'b0);

        drive(2'd1, 2'b00, 2'd2, 1'b0, 5'd7);
        cyc();
        lit4("word_mis", 1'b1, 32'h0, 1'b0, 1'b1);

        drive(2'd1, 2'b11, 2'd0, 1'b0, 5'd7);
        cyc();
        lit4("rsvd_word", 1'b1, 32'h1234ABCD, 1'b1, 1'b0);

        src = {32'h0, 32'h0, 32'h0, 32'hDEADBEEF};
        drive(2'd0, 2'b00, 2'd0, 1'b0, 5'd5);
        cyc();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            src = {$urandom, $urandom, $urandom, $urandom};
            rd  = 5'd9;
            sel = 2'(i);
            cyc();
            lit4("stall", 1'b1, 32'hDEADBEEF, 1'b1, 1'b0);
            chk("stall.reg", 32'(r4), 32'd5);
            chk("stall.ready", 32'(bus4.in_ready), 32'd0);
        end

        flush = 1'b1;
        cyc();
        chk("flush.valid", 32'(v4), 32'd0);
        chk("flush.en",    32'(en4), 32'd0);
        flush = 1'b0;
        stall = 1'b0;

        src = {32'h0, 32'h0, 32'h0, 32'h11112222};
        drive(2'd0, 2'b00, 2'd0, 1'b0, 5'd0);
        cyc();
        lit4("zero_reg", 1'b1, 32'h11112222, 1'b0, 1'b0);

        src = {32'hCAFEF00D, 32'h0, 32'h0, 32'h0};
        drive(2'd3, 2'b00, 2'd0, 1'b0, 5'd8);
        cyc();
        lit4("aux4", 1'b1, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("ill3.data", d3, 32'h0);
        chk("ill3.en",   32'(en3), 32'd0);
        chk("ill3.err",  32'(e3), 32'd0);

        in_valid = 1'b0;
        cyc();
        lit4("idle", 1'b0, 32'hCAFEF00D, 1'b0, 1'b0);

        src = {32'h0, 32'h0, 32'h0, 32'h0BADF00D};
        drive(2'd0, 2'b00, 2'd0, 1'b0, 5'd2);
        cyc();
        #3;
        rst = 1'b1;
        #1;
        lit4("async_rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk("async_rst.reg", 32'(r4), 32'd0);
        src = {32'h0, 32'h00400008, 32'h0, 32'h0};
        drive(2'd2, 2'b00, 2'd0, 1'b0, 5'd31);
        #1;
        rst = 1'b0;
        cyc();
        lit4("link", 1'b1, 32'h00400008, 1'b1, 1'b0);
        chk("link.reg", 32'(r4), 32'd31);

        for (int i = 0; i < 40; i++) begin
            src      = {$urandom, $urandom, $urandom, $urandom};
            sel      = 2'($urandom_range(0, 3));
            ls       = 2'($urandom_range(0, 3));
            off      = 2'($urandom_range(0, 3));
            uns      = 1'($urandom_range(0, 1));
            rw       = 1'($urandom_range(0, 1));
            rd       = 5'($urandom_range(0, 31));
            in_valid = ($urandom_range(0, 3) != 0);
            stall    = ($urandom_range(0, 3) == 0);
            flush    = ($urandom_range(0, 7) == 0);
            cyc();
        end
        stall = 1'b0;
        flush = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/mod_writeback_unit.md
Name: mod_writeback_unit

Overview:
- Parametrised, registered write-back stage for the MIPS core.
- Selects the register-file write data from NUM_SRC result sources: ALU, memory, link (PC+8), and an auxiliary source such as HI/LO.
- Aligns, and sign- or zero-extends, byte and halfword loads.
- Registers the result with valid/stall/flush control, one cycle ahead of the register file write port.

Parameters:
- DATA_W, 32, datapath width in bits; must be 32 when loads narrower than a word are used.
- NUM_SRC, 4, number of write-data sources; minimum 2.
- SEL_W, $clog2(NUM_SRC), width of src_sel.
- MEM_SRC, 1, index of the source that carries raw memory data and receives load alignment.
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst, input, 1, asynchronous, active-high reset.
- in_valid, input, 1, upstream stage presents a valid instruction.
- in_ready, output, 1, stage can accept a new instruction; equals !wb_stall.
- wb_stall, input, 1, hold the output register.
- flush, input, 1, kill the instruction being captured and clear the output valid bit.
- src_data, input, NUM_SRC*DATA_W, concatenated source words; source k occupies bits [k*DATA_W +: DATA_W].
- src_sel, input, SEL_W, source select.
- load_size, input, 2, 00 = word, 01 = half, 10 = byte, 11 = reserved (treated as word).
- load_unsigned, input, 1, zero-extend when set, sign-extend when clear.
- byte_offset, input, 2, effective address bits [1:0].
- reg_write_in, input, 1, instruction writes a register.
- rd_in, input, REG_ADDR_W, destination register.
- wb_valid, output, 1, output register holds a valid instruction.
- write_data, output, DATA_W, register-file write data.
- write_reg, output, REG_ADDR_W, register-file write address.
- reg_write_en, output, 1, register-file write enable.
- misalign_err, output, 1, the held instruction was a misaligned load.

Behaviour:
- Reset (asynchronous, rst=1): wb_valid, write_data, write_reg, reg_write_en and misalign_err are all 0 immediately. They stay 0 until the first capture after rst deasserts. Reset asserted mid-stall discards the held instruction.
- Latency: one cycle. Inputs captured at edge N appear on the outputs after edge N.
- Edge priority, highest first:
  - flush: wb_valid, reg_write_en and misalign_err go to 0. Data and address fields are don't-care. Flush overrides stall and capture.
  - wb_stall: all outputs hold.
  - in_valid=1: capture; wb_valid goes to 1.
  - Otherwise: wb_valid, reg_write_en and misalign_err go to 0.
- Write data when src_sel != MEM_SRC: the selected word, passed through unchanged.
- Write data when src_sel == MEM_SRC, big-endian lane numbering:
  - Byte: offset 0 selects bits [31:24], offset 3 selects bits [7:0].
  - Half: offset 0 selects bits [31:16], offset 2 selects bits [15:0].
  - The selected lane is extended to DATA_W according to load_unsigned.
- Misalignment applies only to the memory source: a half load with byte_offset[0]=1, or a word load with byte_offset!=0.
  - On capture, misalign_err is 1, reg_write_en is 0 and write_data is 0.
- Illegal select (src_sel >= NUM_SRC): write_data is 0, reg_write_en is 0, misalign_err is 0.
- Zero register: reg_write_en = reg_write_in && (rd_in != 0) && no error. $zero is never written.
- in_ready is combinational from wb_stall only. There is no combinational path from in_valid to any output.

Decomposition:
- Shared package (core_pkg) holds:
  - load-size encodings LS_WORD, LS_HALF and LS_BYTE;
  - source indices SRC_ALU=0, SRC_MEM=1, SRC_LINK=2, SRC_AUX=3;
  - the DATA_W and REG_ADDR_W defaults.
- One natural sub-module, mod_load_align: combinational lane select, extension and misalignment detection for the memory source.
- The mux and the output register stay in the top module.

Test Plan:
- Byte load, signed: src_sel=1, mem=0x12F45678, load_size=byte, offset=1, unsigned=0 -> next cycle write_data=0xFFFFFFF4, reg_write_en=1.
- Half load, unsigned: mem=0x8001ABCD, load_size=half, offset=0, unsigned=1 -> write_data=0x00008001. With offset=1 instead -> misalign_err=1, reg_write_en=0, write_data=0.
- Stall hold: capture alu=0xDEADBEEF, rd=5, then wb_stall=1 for 3 cycles while the inputs change -> outputs stay 0xDEADBEEF/5/1 and in_ready=0 throughout.
- Flush priority: flush=1 with wb_stall=1 and in_valid=1 in the same cycle -> wb_valid=0 and reg_write_en=0 next cycle.
- Zero register and illegal select: rd_in=0 with reg_write_in=1 -> reg_write_en=0. With NUM_SRC=3 and src_sel=3 -> write_data=0, reg_write_en=0.
- Async reset mid-operation: assert rst between edges while wb_valid=1 -> all outputs 0 before the next edge. After deassert with in_valid=1, link=0x00400008 -> capture resumes on the first edge.
